reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Generates an ordered set of synchronous reset outputs from one asynchronous active-low board/PLL reset plus a synchronous soft-reset request. It releases domain 0 first, then each subsequent domain after that domain's predecessor reports ready and a fixed hold interval has elapsed. It sits at the top of each clock domain, downstream of the raw reset source, and drives the `sreset` inputs of the blocks in that domain.

## Interface
- `DOMAINS`, 4: number of reset outputs; legal range 1..32.
- `MIN_ASSERT`, 8: cycles during which all outputs stay asserted after the internal reset releases or after a soft request; must be at least 1.
- `HOLD_CYCLES`, 16: cycles between sampling `ready[k]` high and releasing domain k+1; must be at least 1.
- `clk` in 1: clock.
- `areset_n` in 1: one clock; reset is asynchronous and active-low.
- `soft_req` in 1: synchronous soft-reset request, level-sensitive.
- `ready` in DOMAINS: per-domain "initialised" status, synchronous to `clk`; tie high if unused.
- `sreset` out DOMAINS: active-high reset per domain; bit 0 is released first.
- `done` out 1: all domains are released and the last one is ready.

## Operation
- `areset_n` passes through an internal synchroniser with ACTIVE_LEVEL 0 and EXTRA_STAGES 1, giving asynchronous assert and 2-cycle synchronous deassert. The synchroniser output asynchronously resets every state register.
- Reset values: `sreset` = all ones, `done` = 0, state = ASSERT, counter = 0, index = 0.
- FSM states:
  - **ASSERT**: counter increments each cycle. When the counter reaches MIN_ASSERT-1, the next state is WAIT_READY, `sreset[0]` clears, and the counter clears.
  - **WAIT_READY**: waits for `ready[index]`.
    - If `ready[index]` is 1 and index is DOMAINS-1, go to DONE and set `done`.
    - If `ready[index]` is 1 otherwise, go to HOLD with the counter cleared.
  - **HOLD**: counter increments. At HOLD_CYCLES-1, clear `sreset[index+1]`, increment index, and go to WAIT_READY.
  - **DONE**: terminal state until a soft request or async reset.
- `soft_req` = 1 sampled in any state:
  - Next state is ASSERT; counter and index clear.
  - `sreset` returns to all ones and `done` drops, both on the same edge.
  - Holding `soft_req` high keeps the counter at 0, so the assert time is extended; the MIN_ASSERT count starts on the first edge with `soft_req` = 0.
- Simultaneous events: `soft_req` has priority over every release or DONE transition on the same edge.
- `ready[k]` is ignored outside WAIT_READY for index k. A later drop of `ready[k]` has no effect.
- All `sreset` bits are driven directly from flops, with no combinational outputs. Released bits form a contiguous low-order run.
- Counter width is $clog2(max(MIN_ASSERT, HOLD_CYCLES)); minimum 1 bit.
- Async reset mid-sequence: all outputs reassert immediately, without waiting for a clock edge.

## Timing
- Edge E0 is the first rising edge with `areset_n` = 1. The internal reset releases after E1, and state counting starts at E2.
- `sreset[0]` falls after edge E(1+MIN_ASSERT).
- `sreset[k+1]` falls HOLD_CYCLES edges after the first edge that samples `ready[k]` = 1 in WAIT_READY. With `ready` tied high, consecutive releases are HOLD_CYCLES+1 cycles apart.
- `done` rises one edge after `ready[DOMAINS-1]` is first sampled high in WAIT_READY, at the earliest one cycle after the last release.
- `soft_req` latency: one edge to reassertion.

## Structure
- Package `reset_sequencer_pkg` holds the state enum (ASSERT, WAIT_READY, HOLD, DONE) and a `CNT_W` helper function.
- The existing `areset_synchronizer` is instantiated once as the only sub-module. Sequencing logic stays flat in this module.

## Test plan
1. **Power-on.** Defaults, `ready` tied to 1, `areset_n` rising before E0:
   - `sreset` = 4'b1111 through E8; 4'b1110 after E9; 4'b1100 after E26; 4'b1000 after E43; 4'b0000 after E60.
   - `done` = 1 after E61.
2. **Ready stall.**
   - `ready[1]` is held 0 for 40 cycles after `sreset[1]` falls.
   - `sreset[2]` stays 1 until 16 edges after `ready[1]` is first sampled high.
   - `done` stays 0 throughout.
3. **Soft request.**
   - A 1-cycle `soft_req` in DONE makes `sreset` 4'b1111 and `done` 0 on the next edge.
   - `sreset[0]` falls 8 edges later.
   - A 5-cycle `soft_req` delays the `sreset[0]` release by 4 extra cycles.
4. **Collision.** `soft_req` asserted on the same edge as the `sreset[2]` release: `sreset[2]` never falls and all bits read 1.
5. **Async reset mid-HOLD.**
   - `areset_n` pulled low between edges: `sreset` goes to all ones and `done` to 0 before the next edge.
   - After release, the scenario 1 timing repeats exactly.
6. **Parameter corners.** DOMAINS=1, MIN_ASSERT=1, HOLD_CYCLES=1:
   - `sreset[0]` falls after E2.
   - `done` rises after E3.
   - No counter overflow or X on any output.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the ordered reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ASSERT     = 2'd0,
    WAIT_READY = 2'd1,
    HOLD       = 2'd2,
    DONE       = 2'd3
  } state_e;

  // Counter width that can hold 0 .. max(a, b)-1, never narrower than one bit.
  function automatic int unsigned CNT_W(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the domains it releases.
interface reset_sequencer_if #(
  parameter int unsigned DOMAINS = 4
) ();

  logic               soft_req;
  logic [DOMAINS-1:0] ready;
  logic [DOMAINS-1:0] sreset;
  logic               done;

  modport master (
    input  soft_req,
    input  ready,
    output sreset,
    output done
  );

  modport slave (
    output soft_req,
    output ready,
    input  sreset,
    input  done
  );

endinterface

// File: rtl/areset_synchronizer.sv
// Reset synchroniser: asynchronous assert, (1+EXTRA_STAGES)-cycle synchronous deassert.
module areset_synchronizer #(
  parameter bit          ACTIVE_LEVEL = 1'b0,
  parameter int unsigned EXTRA_STAGES = 1
) (
  input  logic clk,
  input  logic arst_i,
  output logic rst_n_o
);

  localparam int unsigned STAGES = EXTRA_STAGES + 1;

  logic              arst_n;
  logic [STAGES-1:0] sync_q;

  assign arst_n = arst_i ^ ACTIVE_LEVEL;

  // Shift ones in once the raw reset is inactive; any assertion clears the chain at once.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(1);
    end
  end

  assign rst_n_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-domain synchronous resets in order, gated by each predecessor's ready and a hold time.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned DOMAINS     = 4,
  parameter int unsigned MIN_ASSERT  = 8,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              areset_n,
  reset_sequencer_if.master bus
);

  localparam int unsigned CW = CNT_W(MIN_ASSERT, HOLD_CYCLES);
  localparam int unsigned IW = (DOMAINS < 2) ? 1 : $clog2(DOMAINS);

  logic               rst_n;
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [DOMAINS-1:0] sreset_q, sreset_d;
  logic               done_q, done_d;
  logic               ready_sel_c;

  areset_synchronizer #(
    .ACTIVE_LEVEL (1'b0),
    .EXTRA_STAGES (1)
  ) u_sync (
    .clk     (clk),
    .arst_i  (areset_n),
    .rst_n_o (rst_n)
  );

  assign ready_sel_c = |(bus.ready & (DOMAINS'(1) << idx_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ASSERT;
      cnt_q    <= '0;
      idx_q    <= '0;
      sreset_q <= '1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sreset_q <= sreset_d;
      done_q   <= done_d;
    end
  end

  // Releases shift a zero in from bit 0, so released domains are always a low-order run.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sreset_d = sreset_q;
    done_d   = done_q;

    if (bus.soft_req) begin
      state_d  = ASSERT;
      cnt_d    = '0;
      idx_d    = '0;
      sreset_d = '1;
      done_d   = 1'b0;
    end else begin
      unique case (state_q)
        ASSERT: begin
          if (cnt_q == CW'(MIN_ASSERT - 1)) begin
            state_d  = WAIT_READY;
            cnt_d    = '0;
            sreset_d = sreset_q << 1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WAIT_READY: begin
          if (ready_sel_c) begin
            if (idx_q == IW'(DOMAINS - 1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = HOLD;
              cnt_d   = '0;
            end
          end
        end
        HOLD: begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            state_d  = WAIT_READY;
            cnt_d    = '0;
            idx_d    = idx_q + IW'(1);
            sreset_d = sreset_q << 1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = ASSERT;
        end
      endcase
    end
  end

  assign bus.sreset = sreset_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timeline scoreboard for a default and a minimal-parameter instance.
module tb_reset_sequencer;

  typedef struct {
    int         edge_n;
    logic [3:0] sreset;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic areset_n;
  int   eidx     = -1000;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_m[$];
  exp_t sb_c[$];
  exp_t em;
  exp_t ec;

  reset_sequencer_if #(.DOMAINS(4)) bus ();
  reset_sequencer_if #(.DOMAINS(1)) cbus ();

  reset_sequencer #(.DOMAINS(4), .MIN_ASSERT(8), .HOLD_CYCLES(16)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus.master)
  );

  reset_sequencer #(.DOMAINS(1), .MIN_ASSERT(1), .HOLD_CYCLES(1)) dut_c (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (cbus.master)
  );

  always #5 clk = ~clk;

  // eidx == n between edge En and E(n+1)
  always @(posedge clk) eidx = eidx + 1;

  always @(negedge clk) begin
    while (sb_m.size() != 0 && sb_m[0].edge_n <= eidx) begin
      em = sb_m.pop_front();
      n_checks++;
      if (em.edge_n != eidx || bus.sreset !== em.sreset || bus.done !== em.done) begin
        n_fail++;
        $display("FAIL sb_main edge %0d (now %0d): sreset=%b done=%b, expected sreset=%b done=%b",
                 em.edge_n, eidx, bus.sreset, bus.done, em.sreset, em.done);
      end
    end
    while (sb_c.size() != 0 && sb_c[0].edge_n <= eidx) begin
      ec = sb_c.pop_front();
      n_checks++;
      if (ec.edge_n != eidx || cbus.sreset !== ec.sreset[0:0] || cbus.done !== ec.done) begin
        n_fail++;
        $display("FAIL sb_corner edge %0d (now %0d): sreset=%b done=%b, expected sreset=%b done=%b",
                 ec.edge_n, eidx, cbus.sreset, cbus.done, ec.sreset[0], ec.done);
      end
    end
  end

  // Bit k is still asserted while n is below its release edge rk.
  function automatic logic [3:0] rel_vec(int n, int r0, int r1, int r2, int r3);
    return {n < r3, n < r2, n < r1, n < r0};
  endfunction

  task automatic push_main(int from, int to, int r0, int r1, int r2, int r3, int dn);
    exp_t e;
    for (int n = from; n <= to; n++) begin
      e.edge_n = n;
      e.sreset = rel_vec(n, r0, r1, r2, r3);
      e.done   = (n >= dn);
      sb_m.push_back(e);
    end
  endtask

  task automatic push_corner(int from, int to, int r0, int dn);
    exp_t e;
    for (int n = from; n <= to; n++) begin
      e.edge_n = n;
      e.sreset = {3'b000, n < r0};
      e.done   = (n >= dn);
      sb_c.push_back(e);
    end
  endtask

  task automatic wait_edge(int target);
    for (int i = 0; i < 1000 && eidx != target; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    areset_n      = 1'b0;
    bus.soft_req  = 1'b0;
    bus.ready     = 4'hF;
    cbus.soft_req = 1'b0;
    cbus.ready    = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.sreset !== 4'hF || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_main: sreset=%b done=%b, expected 1111/0", bus.sreset, bus.done);
    end
    n_checks++;
    if (cbus.sreset !== 1'b1 || cbus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_corner: sreset=%b done=%b, expected 1/0", cbus.sreset, cbus.done);
    end
    #2;
    areset_n = 1'b1;
    eidx     = -1;
    push_main(0, 65, 9, 26, 43, 60, 61);
    push_corner(0, 5, 2, 3);
    for (int i = 0; i < 200 && (sb_m.size() + sb_c.size()) != 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if ((sb_m.size() + sb_c.size()) != 0) begin
      n_fail++;
      $display("FAIL drain_reset: %0d entries left, expected 0", sb_m.size() + sb_c.size());
      sb_m.delete();
      sb_c.delete();
    end
  endtask

  task automatic test_corner();
    int s;
    @(negedge clk);
    #2;
    cbus.soft_req = 1'b1;
    s = eidx + 1;
    push_corner(s, s + 5, s + 1, s + 2);
    @(negedge clk);
    #2;
    cbus.soft_req = 1'b0;
    for (int i = 0; i < 50 && sb_c.size() != 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb_c.size() != 0) begin
      n_fail++;
      $display("FAIL drain_corner: %0d entries left, expected 0", sb_c.size());
      sb_c.delete();
    end
  endtask

  task automatic test_ready_stall();
    int s;
    @(negedge clk);
    #2;
    bus.ready    = 4'b1101;
    bus.soft_req = 1'b1;
    s = eidx + 1;
    push_main(s, s + 105, s + 8, s + 25, s + 82, s + 99, s + 100);
    @(negedge clk);
    #2;
    bus.soft_req = 1'b0;
    wait_edge(s + 65);
    #2;
    bus.ready = 4'hF;
    for (int i = 0; i < 300 && sb_m.size() != 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb_m.size() != 0) begin
      n_fail++;
      $display("FAIL drain_stall: %0d entries left, expected 0", sb_m.size());
      sb_m.delete();
    end
  endtask

  task automatic test_soft_req();
    int s;
    for (int len = 1; len <= 5; len += 4) begin
      @(negedge clk);
      #2;
      bus.soft_req = 1'b1;
      s = eidx + 1;
      push_main(s, s + 66, s + 7 + len, s + 24 + len, s + 41 + len, s + 58 + len, s + 59 + len);
      repeat (len) @(negedge clk);
      #2;
      bus.soft_req = 1'b0;
      for (int i = 0; i < 200 && sb_m.size() != 0; i++) @(negedge clk);
      #1;
      n_checks++;
      if (sb_m.size() != 0) begin
        n_fail++;
        $display("FAIL drain_soft_len%0d: %0d entries left, expected 0", len, sb_m.size());
        sb_m.delete();
      end
    end
  endtask

  task automatic test_collision();
    int s;
    @(negedge clk);
    #2;
    bus.soft_req = 1'b1;
    s = eidx + 1;
    push_main(s, s + 41, s + 8, s + 25, s + 42, s + 59, s + 60);
    push_main(s + 42, s + 105, s + 50, s + 67, s + 84, s + 101, s + 102);
    @(negedge clk);
    #2;
    bus.soft_req = 1'b0;
    wait_edge(s + 41);
    #2;
    bus.soft_req = 1'b1;
    @(negedge clk);
    #2;
    bus.soft_req = 1'b0;
    for (int i = 0; i < 300 && sb_m.size() != 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb_m.size() != 0) begin
      n_fail++;
      $display("FAIL drain_collision: %0d entries left, expected 0", sb_m.size());
      sb_m.delete();
    end
  endtask

  task automatic test_async_reset();
    int s;
    @(negedge clk);
    #2;
    bus.soft_req = 1'b1;
    s = eidx + 1;
    push_main(s, s + 15, s + 8, s + 25, s + 42, s + 59, s + 60);
    @(negedge clk);
    #2;
    bus.soft_req = 1'b0;
    wait_edge(s + 15);
    #2;
    areset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.sreset !== 4'hF || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_main: sreset=%b done=%b, expected 1111/0", bus.sreset, bus.done);
    end
    n_checks++;
    if (cbus.sreset !== 1'b1 || cbus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_corner: sreset=%b done=%b, expected 1/0", cbus.sreset, cbus.done);
    end
    n_checks++;
    if (sb_m.size() != 0) begin
      n_fail++;
      $display("FAIL drain_pre_async: %0d entries left, expected 0", sb_m.size());
      sb_m.delete();
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.sreset !== 4'hF || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_hold: sreset=%b done=%b, expected 1111/0", bus.sreset, bus.done);
    end
    #2;
    areset_n = 1'b1;
    eidx     = -1;
    push_main(0, 65, 9, 26, 43, 60, 61);
    push_corner(0, 5, 2, 3);
    for (int i = 0; i < 200 && (sb_m.size() + sb_c.size()) != 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if ((sb_m.size() + sb_c.size()) != 0) begin
      n_fail++;
      $display("FAIL drain_async: %0d entries left, expected 0", sb_m.size() + sb_c.size());
      sb_m.delete();
      sb_c.delete();
    end
  endtask

  initial begin
    test_reset();
    test_corner();
    test_ready_stall();
    test_soft_req();
    test_collision();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
